div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_abs.sv | 20 ++
 rtl/div_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_div_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: operation encodings,
// FSM state encoding and small operation-decode helpers.
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } div_state_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_abs.sv
// Conditional two's-complement negation. Used both to take the magnitude of
// a signed operand (neg = sign bit) and to restore the sign of a result.
module div_abs #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    // Negate when requested, otherwise pass the value through unchanged
    always_comb begin
        if (neg) begin
            res = (~val) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider (DIV/DIVU/REM/REMU).
// Divide-by-zero and signed overflow finish in one cycle; everything else
// takes N CALC cycles plus one FIX cycle for sign correction.
// Optional feature macro: DIV_WORD_EN adds in_word for 32-bit W-form ops.
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_start,
    input  logic [1:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_dividend,
    input  logic [DATA_WIDTH-1:0] in_divisor,
`ifdef DIV_WORD_EN
    input  logic                  in_word,
`endif
    output logic                  out_busy,
    output logic                  out_done,
    output logic [DATA_WIDTH-1:0] out_result
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [DATA_WIDTH-1:0] ALL_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONE  = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_state_t            state_r, state_nxt_s;
    logic [1:0]            op_r;
    logic                  neg_q_r, neg_r_r;
    logic [DATA_WIDTH-1:0] quo_r, rem_r, dvs_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  out_busy_r, out_done_r;
    logic [DATA_WIDTH-1:0] out_result_r;

    logic                  busy_nxt_s, done_nxt_s;
    logic [DATA_WIDTH-1:0] result_nxt_s;
    logic                  accept_s, signed_s, is_rem_s, div_zero_s, ovf_s, special_s;
    logic                  dvd_neg_s, dvs_neg_s, fix_neg_s;
    logic [DATA_WIDTH-1:0] dvd_ext_s, dvs_ext_s, min_neg_s, dvd_mag_s, dvs_mag_s;
    logic [DATA_WIDTH-1:0] special_raw_s, special_val_s, quo_load_s;
    logic [DATA_WIDTH-1:0] fix_sel_s, fix_val_s, fix_final_s;
    logic [CNT_W-1:0]      cnt_load_s;
    logic [DATA_WIDTH:0]   trial_s;

`ifdef DIV_WORD_EN
    logic word_r;

    function automatic logic [DATA_WIDTH-1:0] sext32(input logic [31:0] v);
        return {{(DATA_WIDTH-32){v[31]}}, v};
    endfunction
`endif

    assign accept_s = (state_r == ST_IDLE) && in_start;
    assign signed_s = op_is_signed(in_op);
    assign is_rem_s = op_is_rem(in_op);

    // Extend incoming operands to the working width (word ops use the low half)
    always_comb begin
        dvd_ext_s = in_dividend;
        dvs_ext_s = in_divisor;
        min_neg_s = MIN_NEG;
`ifdef DIV_WORD_EN
        if (in_word) begin
            dvd_ext_s = signed_s ? sext32(in_dividend[31:0]) : {{(DATA_WIDTH-32){1'b0}}, in_dividend[31:0]};
            dvs_ext_s = signed_s ? sext32(in_divisor[31:0])  : {{(DATA_WIDTH-32){1'b0}}, in_divisor[31:0]};
            min_neg_s = sext32(32'h8000_0000);
        end else begin
            min_neg_s = MIN_NEG;
        end
`endif
    end

    assign dvd_neg_s  = signed_s & dvd_ext_s[DATA_WIDTH-1];
    assign dvs_neg_s  = signed_s & dvs_ext_s[DATA_WIDTH-1];
    assign div_zero_s = (dvs_ext_s == ALL_ZERO);
    assign ovf_s      = signed_s && (dvd_ext_s == min_neg_s) && (dvs_ext_s == ALL_ONE);
    assign special_s  = div_zero_s | ovf_s;

    div_abs #(.WIDTH(DATA_WIDTH)) u_abs_dvd (.val(dvd_ext_s), .neg(dvd_neg_s), .res(dvd_mag_s));
    div_abs #(.WIDTH(DATA_WIDTH)) u_abs_dvs (.val(dvs_ext_s), .neg(dvs_neg_s), .res(dvs_mag_s));

    // Short-circuit results: x/0 gives all ones / dividend, overflow gives dividend / 0
    always_comb begin
        if (div_zero_s) begin
            special_raw_s = is_rem_s ? dvd_ext_s : ALL_ONE;
        end else begin
            special_raw_s = is_rem_s ? ALL_ZERO : dvd_ext_s;
        end
        special_val_s = special_raw_s;
`ifdef DIV_WORD_EN
        if (in_word) begin
            special_val_s = sext32(special_raw_s[31:0]);
        end else begin
            special_val_s = special_raw_s;
        end
`endif
    end

    // Word ops park the magnitude at the top so 32 shifts consume exactly its bits
    always_comb begin
        quo_load_s = dvd_mag_s;
        cnt_load_s = CNT_W'(DATA_WIDTH);
`ifdef DIV_WORD_EN
        if (in_word) begin
            quo_load_s = dvd_mag_s << (DATA_WIDTH - 32);
            cnt_load_s = CNT_W'(32);
        end else begin
            quo_load_s = dvd_mag_s;
        end
`endif
    end

    // One restoring step: shift in the next dividend bit and try the subtract
    assign trial_s = {rem_r, quo_r[DATA_WIDTH-1]} - {1'b0, dvs_r};

    assign fix_sel_s = op_is_rem(op_r) ? rem_r : quo_r;
    assign fix_neg_s = op_is_rem(op_r) ? neg_r_r : neg_q_r;

    div_abs #(.WIDTH(DATA_WIDTH)) u_abs_fix (.val(fix_sel_s), .neg(fix_neg_s), .res(fix_val_s));

    // Sign-extend the corrected word result, full-width ops pass through
    always_comb begin
        fix_final_s = fix_val_s;
`ifdef DIV_WORD_EN
        if (word_r) begin
            fix_final_s = sext32(fix_val_s[31:0]);
        end else begin
            fix_final_s = fix_val_s;
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_start) begin
                    state_nxt_s = special_s ? ST_DONE : ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_FIX:  state_nxt_s = ST_DONE;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs
    always_comb begin
        busy_nxt_s   = (state_nxt_s == ST_CALC) || (state_nxt_s == ST_FIX);
        done_nxt_s   = (state_nxt_s == ST_DONE);
        result_nxt_s = out_result_r;
        if (accept_s && special_s) begin
            result_nxt_s = special_val_s;
        end else if (state_r == ST_FIX) begin
            result_nxt_s = fix_final_s;
        end else begin
            result_nxt_s = out_result_r;
        end
    end

    // Registered outputs; out_result holds between completions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_busy_r   <= 1'b0;
            out_done_r   <= 1'b0;
            out_result_r <= ALL_ZERO;
        end else begin
            out_busy_r   <= busy_nxt_s;
            out_done_r   <= done_nxt_s;
            out_result_r <= result_nxt_s;
        end
    end

    // Datapath: capture operands on accept, then iterate while in CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= 2'b00;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            quo_r   <= ALL_ZERO;
            rem_r   <= ALL_ZERO;
            dvs_r   <= ALL_ZERO;
            cnt_r   <= {CNT_W{1'b0}};
`ifdef DIV_WORD_EN
            word_r  <= 1'b0;
`endif
        end else if (accept_s) begin
            op_r    <= in_op;
            neg_q_r <= dvd_neg_s ^ dvs_neg_s;
            neg_r_r <= dvd_neg_s;
            quo_r   <= quo_load_s;
            rem_r   <= ALL_ZERO;
            dvs_r   <= dvs_mag_s;
            cnt_r   <= cnt_load_s;
`ifdef DIV_WORD_EN
            word_r  <= in_word;
`endif
        end else if (state_r == ST_CALC) begin
            if (!trial_s[DATA_WIDTH]) begin
                rem_r <= trial_s[DATA_WIDTH-1:0];
                quo_r <= {quo_r[DATA_WIDTH-2:0], 1'b1};
            end else begin
                rem_r <= {rem_r[DATA_WIDTH-2:0], quo_r[DATA_WIDTH-1]};
                quo_r <= {quo_r[DATA_WIDTH-2:0], 1'b0};
            end
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign out_busy   = out_busy_r;
    assign out_done   = out_done_r;
    assign out_result = out_result_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random
// operations checked against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_start = 1'b0;
    logic [1:0]  in_op = 2'b00;
    logic [63:0] in_dividend = 64'd0;
    logic [63:0] in_divisor = 64'd0;
    logic        in_word = 1'b0;
    logic        out_busy, out_done;
    logic [63:0] out_result;

    int checks = 0;
    int failures = 0;

    div_unit #(.DATA_WIDTH(64)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_start(in_start),
        .in_op(in_op),
        .in_dividend(in_dividend),
        .in_divisor(in_divisor),
`ifdef DIV_WORD_EN
        .in_word(in_word),
`endif
        .out_busy(out_busy),
        .out_done(out_done),
        .out_result(out_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic plus the architectural special-case rules.
    function automatic void ref_model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                      input logic w, output logic [63:0] res, output int lat);
        bit is_rem, sgn;
        longint sa, sb;
        longint unsigned ua, ub;
        int sa32, sb32;
        int unsigned ua32, ub32;
        logic [31:0] r32;
        is_rem = op[1];
        sgn = !op[0];
        if (!w) begin
            sa = a; sb = b; ua = a; ub = b;
            lat = 66;
            if (ub == 64'd0) begin
                res = is_rem ? a : 64'hFFFF_FFFF_FFFF_FFFF; lat = 1;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                res = is_rem ? 64'd0 : a; lat = 1;
            end else if (sgn) begin
                res = is_rem ? sa % sb : sa / sb;
            end else begin
                res = is_rem ? ua % ub : ua / ub;
            end
        end else begin
            sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
            lat = 34;
            if (ub32 == 32'd0) begin
                r32 = is_rem ? a[31:0] : 32'hFFFF_FFFF; lat = 1;
            end else if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                r32 = is_rem ? 32'd0 : a[31:0]; lat = 1;
            end else if (sgn) begin
                r32 = is_rem ? sa32 % sb32 : sa32 / sb32;
            end else begin
                r32 = is_rem ? ua32 % ub32 : ua32 / ub32;
            end
            res = {{32{r32[31]}}, r32};
        end
    endfunction

    task automatic scramble();
        in_dividend = {$urandom, $urandom};
        in_divisor  = {$urandom, $urandom};
        in_op       = 2'($urandom_range(0, 3));
    endtask

    // One operation: start, optional extra start in busy (poke) and in DONE,
    // then check latency, busy shape, result, single-cycle done and hold.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic w, input logic [63:0] exp_res,
                          input int exp_lat, input int poke, input bit start_in_done);
        int done_cyc;
        int c;
        bit busy_ok;
        logic [63:0] got;
        done_cyc = -1;
        busy_ok = 1'b1;
        got = 64'd0;
        @(negedge clk);
        in_op = op; in_dividend = a; in_divisor = b; in_word = w; in_start = 1'b1;
        @(posedge clk); #1;
        in_start = 1'b0;
        scramble();
        c = 1;
        while (c <= 80 && done_cyc < 0) begin
            if (out_done === 1'b1) begin
                done_cyc = c;
                got = out_result;
                if (out_busy !== 1'b0) busy_ok = 1'b0;
                in_start = start_in_done;
            end else begin
                if (out_busy !== 1'b1) busy_ok = 1'b0;
                in_start = (c == poke);
                @(posedge clk); #1;
                c++;
            end
        end
        check({tag, "_latency"}, 64'(done_cyc), 64'(exp_lat));
        check({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
        check({tag, "_result"}, got, exp_res);
        @(posedge clk); #1;
        in_start = 1'b0;
        check({tag, "_idle_after"}, {62'd0, out_done, out_busy}, 64'd0);
        check({tag, "_hold"}, out_result, exp_res);
    endtask

    initial begin
        logic [63:0] r;
        logic [63:0] a, b;
        logic [1:0]  op;
        logic        w;
        int          lat;
        int          done_seen;

        // Reset state
        #12;
        check("reset_busy", {63'd0, out_busy}, 64'd0);
        check("reset_done", {63'd0, out_done}, 64'd0);
        check("reset_result", out_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases
        run_op("divu_100_7", 2'b01, 64'd100, 64'd7, 1'b0, 64'd14, 66, 0, 1'b0);
        run_op("rem_m100_7", 2'b10, -64'sd100, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0, 1'b0);
        run_op("div_m100_7", 2'b00, -64'sd100, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 66, 10, 1'b1);
        run_op("div_5_0", 2'b00, 64'd5, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1'b1);
        run_op("remu_5_0", 2'b11, 64'd5, 64'd0, 1'b0, 64'd5, 1, 0, 1'b0);
        run_op("div_ovf", 2'b00, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
               64'h8000_0000_0000_0000, 1, 0, 1'b0);
        run_op("rem_ovf", 2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1, 0, 1'b0);
        run_op("div_minneg_2", 2'b00, 64'h8000_0000_0000_0000, 64'd2, 1'b0, 64'hC000_0000_0000_0000, 66, 0, 1'b0);
        run_op("divu_max_1", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0, 1'b0);

        // Start, ignored second start at cycle 10, reset at cycle 30
        @(negedge clk);
        in_op = 2'b01; in_dividend = 64'd1000; in_divisor = 64'd3; in_start = 1'b1;
        @(posedge clk); #1;
        in_start = 1'b0;
        done_seen = 0;
        for (int c = 1; c < 30; c++) begin
            if (out_done === 1'b1) done_seen++;
            in_start = (c == 10);
            if (c == 10) scramble();
            @(posedge clk); #1;
        end
        in_start = 1'b0;
        check("abort_busy_before_reset", {63'd0, out_busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, out_busy}, 64'd0);
        check("abort_done", {63'd0, out_done}, 64'd0);
        check("abort_result", out_result, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (out_done === 1'b1) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        run_op("after_reset", 2'b01, 64'd1000, 64'd3, 1'b0, 64'd333, 66, 0, 1'b0);

`ifdef DIV_WORD_EN
        run_op("divw", 2'b00, 64'h1_FFFF_FFF0, 64'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 34, 0, 1'b0);
`endif

        // Random operations against the reference model
        for (int i = 0; i < 16; i++) begin
            op = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: b = 64'($urandom_range(1, 1000));
                1: b = -64'($urandom_range(1, 1000));
                2: b = 64'd0;
                3: begin a = 64'h8000_0000_0000_0000; b = 64'hFFFF_FFFF_FFFF_FFFF; end
                default: b = {$urandom, $urandom};
            endcase
            w = 1'b0;
`ifdef DIV_WORD_EN
            w = 1'($urandom_range(0, 1));
            if (w && b == 64'hFFFF_FFFF_FFFF_FFFF) a[31:0] = 32'h8000_0000;
`endif
            ref_model(op, a, b, w, r, lat);
            run_op($sformatf("rand%0d", i), op, a, b, w, r, lat, (lat > 12) ? 7 : 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
